// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a shared 4:1 single-bit mux path.
// Grants one requester per bounded tenure and steers its data bit to out_o.
`default_nettype none

module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [3:0] req_i,
  input  logic [3:0] d_i,
  output logic [3:0] grant_o,
  output logic [1:0] sel_o,
  output logic       out_o,
  output logic       busy_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ptr_q, ptr_d;

  logic [1:0]       w_base;
  logic [1:0]       w_winner;
  logic             w_release;

  // Offsets are scanned from farthest to nearest so the nearest set bit
  // after ptr wins; offset 4 (== ptr itself) gives the owner lowest priority.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  assign w_base    = (state_q == ST_GRANT) ? sel_q : ptr_q;
  assign w_winner  = rr_pick(req_i, w_base);
  assign w_release = !req_i[sel_q] || (cnt_q == C_LAST_CNT);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (en_i && (|req_i)) begin
          state_d = ST_GRANT;
          grant_d = 4'b0001 << w_winner;
          sel_d   = w_winner;
          busy_d  = 1'b1;
          cnt_d   = '0;
          ptr_d   = w_winner;
        end
      end
      ST_GRANT: begin
        if (!w_release) begin
          cnt_d = cnt_q + 1'b1;
        end else if (en_i && (|req_i)) begin
          grant_d = 4'b0001 << w_winner;
          sel_d   = w_winner;
          cnt_d   = '0;
          ptr_d   = w_winner;
        end else begin
          state_d = ST_IDLE;
          grant_d = 4'b0000;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= 4'b0000;
      sel_q   <= 2'b00;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant_o = grant_q;
  assign sel_o   = sel_q;
  assign busy_o  = busy_q;
  assign out_o   = (|grant_q) ? d_i[sel_q] : 1'b0;

endmodule

`default_nettype wire

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 single-bit mux path between four requesters. It owns the mux select. It grants one requester at a time, holds the grant for a bounded tenure, and steers that requester's data bit to the shared output. It sits directly in front of the 4:1 LUT mux datapath and is the only driver of its select lines.

Parameters:
MAX_HOLD, 4, maximum tenure in cycles per grant; legal range 1..255
CNT_W, 8, width of the internal tenure counter; must hold MAX_HOLD-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
en  input  1  arbitration enable; low blocks new grants, current tenure completes
req  input  4  request per requester, bit i = requester i
d  input  4  data bit per requester, bit i = requester i
grant  output  4  one-hot grant, registered; all-zero when idle
sel  output  2  mux select, registered; index of current/last owner
out  output  1  d[sel] when any grant bit set, else 0 (combinational)
busy  output  1  high while in GRANT state, registered

Behaviour:
- Reset (async, rst=1): state=IDLE, grant=4'b0000, sel=2'b00, busy=0, tenure counter=0, priority pointer ptr=3 (so requester 0 has top priority first).
- Priority: search starts at (ptr+1) mod 4 and wraps upward; the first set req bit wins. ptr is updated to the winner's index at each grant.
- IDLE: if en=1 and req!=0, then next edge: grant=onehot(winner), sel=winner, busy=1, counter=0, state=GRANT. Latency from req sampled high to grant high is 1 cycle. If en=0 or req=0, stay IDLE with outputs unchanged. sel keeps its last value.
- GRANT: the owner is the index in sel. Each cycle in which no release occurs, counter increments.
- Release condition, evaluated each cycle: req[owner]=0, or counter==MAX_HOLD-1.
- On release with en=1 and another request pending: re-arbitrate the same cycle from ptr=owner. The released owner has lowest priority. The new grant appears at the next edge with no idle cycle, and counter resets to 0.
- On timeout with only the owner still requesting: the owner is regranted as a new tenure. grant stays continuously high and counter resets to 0.
- On release with no eligible request, or with en=0: next edge grant=0, busy=0, state=IDLE. sel is unchanged.
- en falling mid-tenure does not cut the grant. The tenure ends normally.
- MAX_HOLD=1: every grant lasts exactly 1 cycle. Requesters rotate every cycle when multiple req bits are set.
- req bits of non-owners changing during a tenure have no effect until release.
- rst asserted mid-tenure: all outputs return to reset values immediately (asynchronous). ptr returns to 3.
- Invariants:
  - grant is always zero or one-hot.
  - grant!=0 implies grant[sel]=1 and busy=1.
  - out=0 whenever grant=0.

Test Plan:
- Reset then single request: rst pulse, req=4'b0100, d=4'b0100 -> 1 cycle later grant=4'b0100, sel=2, busy=1, out=1. Drop req -> next edge grant=0, busy=0, sel stays 2.
- Round-robin fairness: req=4'b1111 held, MAX_HOLD=4 -> grants in order 0,1,2,3,0, each exactly 4 cycles, with no gap between tenures.
- Early release: req=4'b0011, owner 0 drops req[0] after 2 cycles -> next edge grant=4'b0010. No idle cycle.
- Sole requester timeout: req=4'b1000 held for 10 cycles with MAX_HOLD=4 -> grant=4'b1000 continuous, and the counter wraps to 0 every 4 cycles.
- Enable gating: grant active on requester 1, drive en=0 with req=4'b0011 -> tenure completes, then grant=0 and busy=0. Grant stays idle until en=1, then requester 0 is granted (ptr=1, search order 2,3,0).
- Async reset mid-tenure: rst asserted between clock edges while grant=4'b0010 -> grant=0, sel=0, busy=0 before the next edge. After release with req=4'b0011, requester 0 wins.
